// File: rtl/pipe_stage_elastic.sv
// Elastic inter-stage pipeline register with valid/ready handshake, flush,
// bubble control zeroing and an optional two-entry skid buffer.
module pipe_stage_elastic #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  logic              main_valid;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] main_ctrl;
  logic              skid_valid;
  logic              in_fire;
  logic              out_fire;

  // Outputs are masked during reset so no transfer is reported in that cycle.
  assign out_valid = main_valid & ~reset;
  assign out_data  = reset ? '0 : main_data;
  assign out_ctrl  = out_valid ? main_ctrl : '0;
  assign occupancy = reset ? 2'd0 : ({1'b0, main_valid} + {1'b0, skid_valid});

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  generate
    if (SKID != 0) begin : g_skid
      logic [DATA_W-1:0] skid_data;
      logic [CTRL_W-1:0] skid_ctrl;

      // Ready depends only on held state, breaking the out_ready->in_ready path.
      assign in_ready = ~reset & ~skid_valid;

      always_ff @(posedge clk) begin
        if (reset) begin
          main_valid <= 1'b0;
          main_data  <= '0;
          main_ctrl  <= '0;
          skid_valid <= 1'b0;
          skid_data  <= '0;
          skid_ctrl  <= '0;
        end else if (flush) begin
          main_valid <= 1'b0;
          main_ctrl  <= '0;
          skid_valid <= 1'b0;
          skid_ctrl  <= '0;
        end else if (out_fire || !main_valid) begin
          if (skid_valid) begin
            main_valid <= 1'b1;
            main_data  <= skid_data;
            main_ctrl  <= skid_ctrl;
            skid_valid <= 1'b0;
            skid_ctrl  <= '0;
          end else if (in_fire) begin
            main_valid <= 1'b1;
            main_data  <= in_data;
            main_ctrl  <= in_ctrl;
          end else begin
            main_valid <= 1'b0;
            main_ctrl  <= '0;
          end
        end else if (in_fire) begin
          skid_valid <= 1'b1;
          skid_data  <= in_data;
          skid_ctrl  <= in_ctrl;
        end
      end
    end else begin : g_single
      assign skid_valid = 1'b0;
      assign in_ready   = ~reset & (out_ready | ~main_valid);

      always_ff @(posedge clk) begin
        if (reset) begin
          main_valid <= 1'b0;
          main_data  <= '0;
          main_ctrl  <= '0;
        end else if (flush) begin
          main_valid <= 1'b0;
          main_ctrl  <= '0;
        end else if (in_fire) begin
          main_valid <= 1'b1;
          main_data  <= in_data;
          main_ctrl  <= in_ctrl;
        end else if (out_fire) begin
          main_valid <= 1'b0;
          main_ctrl  <= '0;
        end
      end
    end
  endgenerate

  // The skid entry is always younger than the main entry, so it never exists alone.
  a_skid_implies_main: assert property (@(posedge clk) disable iff (reset)
    skid_valid |-> main_valid);

  a_full_not_ready: assert property (@(posedge clk) disable iff (reset)
    (occupancy == 2'd2) |-> !in_ready);

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: directed table, hand sequences and a randomized
// run of SKID=1 and SKID=0 instances against queue-based reference models.
module tb_pipe_stage_elastic;

  typedef struct {
    logic        iv;
    logic        ordy;
    logic        fl;
    logic [31:0] d;
    logic [7:0]  c;
    logic        e_rdy;
    logic        e_ov;
    logic [31:0] e_od;
    logic [7:0]  e_oc;
    logic [1:0]  e_occ;
  } vec_t;

  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  ctrl;
  } ent_t;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_data;
  logic [7:0]  in_ctrl;
  logic        out_ready;

  logic        in_ready1, out_valid1;
  logic [31:0] out_data1;
  logic [7:0]  out_ctrl1;
  logic [1:0]  occupancy1;

  logic        in_ready0, out_valid0;
  logic [31:0] out_data0;
  logic [7:0]  out_ctrl0;
  logic [1:0]  occupancy0;

  int checks;
  int errors;

  pipe_stage_elastic #(.DATA_W(32), .CTRL_W(8), .SKID(1)) dut1 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
    .out_ctrl(out_ctrl1), .occupancy(occupancy1)
  );

  pipe_stage_elastic #(.DATA_W(32), .CTRL_W(8), .SKID(0)) dut0 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
    .out_ctrl(out_ctrl0), .occupancy(occupancy0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic iv, input logic ordy, input logic fl,
                               input logic [31:0] d, input logic [7:0] c);
    in_valid  = iv;
    out_ready = ordy;
    flush     = fl;
    in_data   = d;
    in_ctrl   = c;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(logic iv, logic ordy, logic fl, logic [31:0] d, logic [7:0] c,
                              logic rdy, logic ov, logic [31:0] od, logic [7:0] oc, logic [1:0] occ);
    vec_t v;
    v.iv = iv; v.ordy = ordy; v.fl = fl; v.d = d; v.c = c;
    v.e_rdy = rdy; v.e_ov = ov; v.e_od = od; v.e_oc = oc; v.e_occ = occ;
    return v;
  endfunction

  vec_t vecs[20];
  ent_t q1[$];
  ent_t q0[$];

  initial begin
    logic rdy1, ov1, rdy0, ov0;
    checks = 0;
    errors = 0;

    // Streaming, back-pressure, flush, bubble and drain-while-filling on SKID=1.
    vecs[0]  = mk(1, 1, 0, 32'h10, 8'h01, 1, 1, 32'h10, 8'h01, 2'd1);
    vecs[1]  = mk(1, 1, 0, 32'h11, 8'h02, 1, 1, 32'h11, 8'h02, 2'd1);
    vecs[2]  = mk(1, 1, 0, 32'h12, 8'h03, 1, 1, 32'h12, 8'h03, 2'd1);
    vecs[3]  = mk(0, 1, 0, 32'h0,  8'h00, 1, 0, 32'h0,  8'h00, 2'd0);
    vecs[4]  = mk(1, 0, 0, 32'hA0, 8'h0A, 1, 1, 32'hA0, 8'h0A, 2'd1);
    vecs[5]  = mk(1, 0, 0, 32'hA1, 8'h0B, 0, 1, 32'hA0, 8'h0A, 2'd2);
    vecs[6]  = mk(1, 0, 0, 32'hA2, 8'h0C, 0, 1, 32'hA0, 8'h0A, 2'd2);
    vecs[7]  = mk(0, 1, 0, 32'h0,  8'h00, 1, 1, 32'hA1, 8'h0B, 2'd1);
    vecs[8]  = mk(0, 1, 0, 32'h0,  8'h00, 1, 0, 32'h0,  8'h00, 2'd0);
    vecs[9]  = mk(1, 0, 0, 32'hB0, 8'h0C, 1, 1, 32'hB0, 8'h0C, 2'd1);
    vecs[10] = mk(1, 0, 0, 32'hB1, 8'h0D, 0, 1, 32'hB0, 8'h0C, 2'd2);
    vecs[11] = mk(1, 0, 1, 32'hFF, 8'h0E, 1, 0, 32'h0,  8'h00, 2'd0);
    vecs[12] = mk(0, 1, 0, 32'h0,  8'h00, 1, 0, 32'h0,  8'h00, 2'd0);
    vecs[13] = mk(1, 0, 0, 32'hC0, 8'h11, 1, 1, 32'hC0, 8'h11, 2'd1);
    vecs[14] = mk(1, 1, 1, 32'hC1, 8'h12, 1, 0, 32'h0,  8'h00, 2'd0);
    vecs[15] = mk(1, 1, 0, 32'h55, 8'h5A, 1, 1, 32'h55, 8'h5A, 2'd1);
    vecs[16] = mk(0, 1, 0, 32'h0,  8'h00, 1, 0, 32'h0,  8'h00, 2'd0);
    vecs[17] = mk(1, 0, 0, 32'hD0, 8'h21, 1, 1, 32'hD0, 8'h21, 2'd1);
    vecs[18] = mk(1, 1, 0, 32'hD1, 8'h22, 1, 1, 32'hD1, 8'h22, 2'd1);
    vecs[19] = mk(0, 1, 0, 32'h0,  8'h00, 1, 0, 32'h0,  8'h00, 2'd0);

    reset = 1'b1;
    applyStimulus(0, 0, 0, 32'h0, 8'h0);
    #1;
    checkOutput("rst_in_ready1", 32'(in_ready1), 32'd0);
    checkOutput("rst_in_ready0", 32'(in_ready0), 32'd0);
    tick();
    reset = 1'b0;
    #1;
    checkOutput("post_rst_in_ready1", 32'(in_ready1), 32'd1);
    checkOutput("post_rst_out_valid1", 32'(out_valid1), 32'd0);
    checkOutput("post_rst_out_data1", out_data1, 32'd0);
    checkOutput("post_rst_out_ctrl1", 32'(out_ctrl1), 32'd0);
    checkOutput("post_rst_occupancy1", 32'(occupancy1), 32'd0);
    checkOutput("post_rst_in_ready0", 32'(in_ready0), 32'd1);

    for (int i = 0; i < 20; i++) begin
      applyStimulus(vecs[i].iv, vecs[i].ordy, vecs[i].fl, vecs[i].d, vecs[i].c);
      tick();
      checkOutput($sformatf("vec%0d_in_ready", i), 32'(in_ready1), 32'(vecs[i].e_rdy));
      checkOutput($sformatf("vec%0d_out_valid", i), 32'(out_valid1), 32'(vecs[i].e_ov));
      checkOutput($sformatf("vec%0d_out_ctrl", i), 32'(out_ctrl1), 32'(vecs[i].e_oc));
      checkOutput($sformatf("vec%0d_occupancy", i), 32'(occupancy1), 32'(vecs[i].e_occ));
      if (vecs[i].e_ov)
        checkOutput($sformatf("vec%0d_out_data", i), out_data1, vecs[i].e_od);
    end

    // Reset while the skid buffer is full.
    applyStimulus(1, 0, 0, 32'hE0, 8'h31);
    tick();
    applyStimulus(1, 0, 0, 32'hE1, 8'h32);
    tick();
    checkOutput("midrst_pre_occupancy", 32'(occupancy1), 32'd2);
    applyStimulus(0, 0, 0, 32'h0, 8'h0);
    reset = 1'b1;
    #1;
    checkOutput("midrst_in_ready", 32'(in_ready1), 32'd0);
    checkOutput("midrst_out_valid", 32'(out_valid1), 32'd0);
    checkOutput("midrst_out_data", out_data1, 32'd0);
    checkOutput("midrst_out_ctrl", 32'(out_ctrl1), 32'd0);
    checkOutput("midrst_occupancy", 32'(occupancy1), 32'd0);
    tick();
    reset = 1'b0;
    #1;
    checkOutput("midrst_after_in_ready", 32'(in_ready1), 32'd1);
    checkOutput("midrst_after_out_valid", 32'(out_valid1), 32'd0);
    checkOutput("midrst_after_occupancy", 32'(occupancy1), 32'd0);
    checkOutput("midrst_after_out_data", out_data1, 32'd0);

    // SKID=0: in_ready follows out_ready combinationally while full.
    applyStimulus(1, 0, 0, 32'h32, 8'h41);
    tick();
    checkOutput("s0_out_valid", 32'(out_valid0), 32'd1);
    checkOutput("s0_out_data", out_data0, 32'h32);
    checkOutput("s0_in_ready_blocked", 32'(in_ready0), 32'd0);
    applyStimulus(1, 1, 0, 32'h33, 8'h42);
    #1;
    checkOutput("s0_in_ready_comb", 32'(in_ready0), 32'd1);
    tick();
    checkOutput("s0_out_data_33", out_data0, 32'h33);
    checkOutput("s0_out_ctrl_42", 32'(out_ctrl0), 32'h42);
    checkOutput("s0_occupancy_1", 32'(occupancy0), 32'd1);
    applyStimulus(0, 1, 0, 32'h0, 8'h0);
    tick();
    checkOutput("s0_drain_out_valid", 32'(out_valid0), 32'd0);
    checkOutput("s0_drain_out_ctrl", 32'(out_ctrl0), 32'd0);
    checkOutput("s0_drain_occupancy", 32'(occupancy0), 32'd0);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    q1.delete();
    q0.delete();

    // Randomized run; both stages are modelled as bounded FIFOs.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                    $urandom_range(0, 15) == 0, $urandom, 8'($urandom));
      reset = ($urandom_range(0, 63) == 0);
      #1;
      rdy1 = !reset && (q1.size() < 2);
      ov1  = !reset && (q1.size() > 0);
      rdy0 = !reset && (out_ready || q0.size() == 0);
      ov0  = !reset && (q0.size() > 0);

      checkOutput("rnd1_in_ready", 32'(in_ready1), 32'(rdy1));
      checkOutput("rnd1_out_valid", 32'(out_valid1), 32'(ov1));
      checkOutput("rnd1_occupancy", 32'(occupancy1), reset ? 32'd0 : 32'(q1.size()));
      checkOutput("rnd1_out_ctrl", 32'(out_ctrl1), ov1 ? 32'(q1[0].ctrl) : 32'd0);
      if (ov1 || reset)
        checkOutput("rnd1_out_data", out_data1, ov1 ? q1[0].data : 32'd0);

      checkOutput("rnd0_in_ready", 32'(in_ready0), 32'(rdy0));
      checkOutput("rnd0_out_valid", 32'(out_valid0), 32'(ov0));
      checkOutput("rnd0_occupancy", 32'(occupancy0), reset ? 32'd0 : 32'(q0.size()));
      checkOutput("rnd0_out_ctrl", 32'(out_ctrl0), ov0 ? 32'(q0[0].ctrl) : 32'd0);
      if (ov0 || reset)
        checkOutput("rnd0_out_data", out_data0, ov0 ? q0[0].data : 32'd0);

      if (reset || flush) begin
        q1.delete();
        q0.delete();
      end else begin
        if (ov1 && out_ready) void'(q1.pop_front());
        if (in_valid && rdy1) q1.push_back('{data: in_data, ctrl: in_ctrl});
        if (ov0 && out_ready) void'(q0.pop_front());
        if (in_valid && rdy0) q0.push_back('{data: in_data, ctrl: in_ctrl});
      end
      tick();
    end
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
- Parametrised successor to the fixed-field inter-stage pipeline registers, such as the MEM/WB boundary.
- Carries a generic data payload and a control payload between two pipeline stages.
- Adds a valid/ready handshake, a flush input and bubble insertion.
- Adds an optional 2-entry skid buffer, so back-pressure does not create a combinational ready path across the stage.
- Instantiated between IF/ID/EX/MEM/WB stages in place of the per-stage hand-written registers.

Parameters:
- DATA_W, 32: width of the data payload (e.g. ALU result, PC, immediate concatenated).
- CTRL_W, 8: width of the control payload (e.g. RW, MD, opcode bits). Forced to 0 whenever the stage holds a bubble.
- SKID, 1: 1 = two-entry elastic stage (main + skid register). 0 = single register, with in_ready = out_ready | ~out_valid.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  discard all held entries this cycle (branch/exception kill).
- in_valid  in  1  upstream has a valid entry.
- in_ready  out  1  stage can accept this cycle.
- in_data  in  DATA_W  upstream data payload.
- in_ctrl  in  CTRL_W  upstream control payload.
- out_valid  out  1  downstream entry valid.
- out_ready  in  1  downstream accepts this cycle.
- out_data  out  DATA_W  head entry data.
- out_ctrl  out  CTRL_W  head entry control; 0 when out_valid=0.
- occupancy  out  2  number of held entries (0..2; max 1 when SKID=0).

Behaviour:
- All state updates on the rising edge of clk. Reset is synchronous, active-high; one clk edge with reset=1 is required.
- Reset values:
  - out_valid=0, out_data=0, out_ctrl=0, occupancy=0.
  - Internal skid_valid=0, skid_data=0, skid_ctrl=0.
  - in_ready is forced to 0 while reset=1. It becomes 1 in the first cycle after reset deasserts.
- Handshake:
  - Input transfer when in_valid & in_ready.
  - Output transfer when out_valid & out_ready.
  - in_data/in_ctrl are ignored unless an input transfer occurs.
  - in_valid may be held across cycles; an entry is captured exactly once per transfer.
- Latency: an accepted entry appears on the outputs the cycle after the transfer (1-cycle latency). No combinational in→out path.
- SKID=1:
  - in_ready = ~skid_valid (registered; no out_ready→in_ready comb path).
  - Main empty, or main draining this cycle, with skid empty: input goes to main.
  - Main full and not draining: input goes to skid.
  - When main drains and skid is valid: skid moves to main and skid_valid clears; a simultaneous input transfer is impossible because in_ready=0.
  - Throughput: 1 entry/cycle sustained when out_ready=1.
- SKID=0:
  - in_ready = out_ready | ~out_valid (combinational).
  - Input transfer loads main. Output transfer without input transfer clears out_valid.
- Flush:
  - Priority over every transfer in the same cycle.
  - Next cycle: out_valid=0, skid_valid=0, out_ctrl=0, occupancy=0.
  - A simultaneous input transfer is dropped.
  - out_data keeps its old value (don't-care).
- Bubble: whenever out_valid=0, out_ctrl is driven 0, so no register-write or memory side-effect leaks downstream.
- Ordering: strictly FIFO; the skid entry is always younger than the main entry.
- Reset vs flush: reset dominates; both yield the same empty state.
- Reset mid-operation: all held entries are lost; no output transfer is reported during the reset cycle (out_valid=0).
- occupancy = out_valid + skid_valid. Never 2 when SKID=0.
- Assertions for verification:
  - skid_valid implies out_valid.
  - in_ready=0 whenever occupancy=2.

Test Plan:
- Streaming: reset, then out_ready=1, in_valid=1 with in_data=0x10,0x11,0x12 on consecutive cycles → out_data shows 0x10,0x11,0x12 one cycle later each, with out_valid=1 continuous and occupancy=1.
- Back-pressure (SKID=1):
  - out_ready=0; send 0xA0 then 0xA1 → occupancy=2, in_ready=0.
  - Then out_ready=1 → 0xA0 then 0xA1 emerge in order, and in_ready returns to 1 one cycle after the first drain.
- Flush with capture: occupancy=2, assert flush together with in_valid=1 and in_data=0xFF → next cycle out_valid=0, out_ctrl=0, occupancy=0, and 0xFF is never emitted.
- Bubble control: in_ctrl=0x5A, then in_valid=0 with out_ready=1 → out_ctrl=0x5A for one cycle, then 0x00 with out_valid=0.
- Reset mid-operation: occupancy=2, reset=1 for one edge → all outputs 0 and in_ready=0 during reset; in_ready=1 the following cycle.
- SKID=0 variant: out_valid=1, out_ready=0 → in_ready=0 in the same cycle. Set out_ready=1 with in_valid=1, in_data=0x33 → in_ready=1 combinationally, and 0x33 is on out_data the next cycle.
